save_entry_ctrl: RTL and testbench

- Upstream stage of the memory save selector.
- Turns raw push-button/keypad inputs into a 2-digit decimal value `num` (0..99, binary-encoded, 8 bits) and a one-cycle `okSAVE` strobe.
- The selector uses these to load `num` into the storage register; otherwise the register recirculates `q`.
- Contains input synchronisers, debouncers, edge detectors and a digit-entry FSM.

---
 rtl/save_entry_ctrl.sv | 101 ++++++++++
 tb/tb_save_entry_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/save_entry_ctrl.sv
// save_entry_ctrl: conditions the raw keypad and button inputs, then assembles a 2-digit decimal value.
// Emits a one-cycle save strobe for the downstream save selector.
module save_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_digit,
    input  logic       key_press,
    input  logic       btn_save,
    input  logic       btn_clear,
    output logic [7:0] num,
    output logic       okSAVE,
    output logic [1:0] n_digits,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, ONE, TWO, SAVE} state_t;

    logic [2:0] raw, s1_q, s2_q, deb_q, deb_prev_q, ev;
    logic [7:0] cnt_q [3];
    state_t     state_q;
    logic [7:0] num_q, num_d;
    logic [1:0] n_q;
    logic       ok_q, err_q, clr_pend_q, clr, digit_bad;

    assign raw       = {btn_clear, btn_save, key_press};
    assign ev        = deb_q & ~deb_prev_q;
    assign clr       = ev[2] | clr_pend_q;
    assign digit_bad = key_digit > 4'd9;
    assign num_d     = (state_q == IDLE) ? {4'd0, key_digit}
                                         : (num_q << 3) + (num_q << 1) + {4'd0, key_digit};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            deb_prev_q <= deb_q;
            for (int k = 0; k < 3; k++) begin
                if (s2_q[k] == deb_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == 8'(DEBOUNCE_CYCLES)) begin
                    deb_q[k] <= s2_q[k];
                    cnt_q[k] <= '0;
                end else begin
                    cnt_q[k] <= cnt_q[k] + 8'd1;
                end
            end
        end
    end

    // A clear seen during the save strobe is held over and applied in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            num_q      <= '0;
            n_q        <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            if (state_q == SAVE) begin
                state_q    <= IDLE;
                n_q        <= 2'd0;
                clr_pend_q <= ev[2];
            end else if (clr) begin
                state_q <= IDLE;
                num_q   <= '0;
                n_q     <= 2'd0;
            end else if (ev[1]) begin
                if (state_q == IDLE) begin
                    err_q <= 1'b1;
                end else begin
                    state_q <= SAVE;
                    ok_q    <= 1'b1;
                end
            end else if (ev[0]) begin
                if (digit_bad || state_q == TWO) begin
                    err_q <= 1'b1;
                end else begin
                    state_q <= (state_q == IDLE) ? ONE : TWO;
                    num_q   <= num_d;
                    n_q     <= n_q + 2'd1;
                end
            end
        end
    end

    assign num      = num_q;
    assign okSAVE   = ok_q;
    assign n_digits = n_q;
    assign err      = err_q;
endmodule

// File: tb/tb_save_entry_ctrl.sv
// tb_save_entry_ctrl: directed and random stimulus for save_entry_ctrl.
// Each cycle is checked against a history-window and digit-list reference model.
module tb_save_entry_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_digit = 4'd0;
    logic       key_press = 1'b0, btn_save = 1'b0, btn_clear = 1'b0;
    logic [7:0] num;
    logic       okSAVE, err;
    logic [1:0] n_digits;

    int checks = 0, failures = 0;
    int cnt_ok = 0, cnt_err = 0;

    save_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .key_digit(key_digit), .key_press(key_press),
        .btn_save(btn_save), .btn_clear(btn_clear), .num(num), .okSAVE(okSAVE),
        .n_digits(n_digits), .err(err)
    );

    always #5 clk = ~clk;

    // Model: bit k of hist is the raw sample k edges ago; a level is accepted once the
    // D+1 synchronised samples (2 edges old and older) all disagree with it.
    logic [63:0] hist [3];
    bit          acc [3];
    bit          ev [3];
    int          entered[$];
    int          m_num;
    bit          m_ok, m_err, saving, pend;

    function automatic void model_step(input logic [2:0] rawv, input int digit, input logic rst);
        bit all_diff, clr;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                hist[c] = '0;
                acc[c]  = 1'b0;
                ev[c]   = 1'b0;
            end
            entered.delete();
            m_num = 0; m_ok = 0; m_err = 0; saving = 0; pend = 0;
            return;
        end
        m_ok = 0;
        m_err = 0;
        if (saving) begin
            saving = 0;
            entered.delete();
            pend = ev[2];
        end else begin
            clr  = ev[2] | pend;
            pend = 0;
            if (clr) begin
                entered.delete();
                m_num = 0;
            end else if (ev[1]) begin
                if (entered.size() == 0) m_err = 1;
                else begin
                    saving = 1;
                    m_ok = 1;
                end
            end else if (ev[0]) begin
                if (digit > 9 || entered.size() == 2) m_err = 1;
                else begin
                    entered.push_back(digit);
                    m_num = (entered.size() == 1) ? entered[0] : entered[0] * 10 + entered[1];
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            hist[c]  = {hist[c][62:0], rawv[c]};
            ev[c]    = 1'b0;
            all_diff = 1'b1;
            for (int k = 2; k <= D + 2; k++) if (hist[c][k] == acc[c]) all_diff = 1'b0;
            if (all_diff) begin
                ev[c]  = !acc[c];
                acc[c] = !acc[c];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step({btn_clear, btn_save, key_press}, int'(key_digit), reset);
        #1;
        chk("num", 32'(num), m_num);
        chk("okSAVE", 32'(okSAVE), int'(m_ok));
        chk("n_digits", 32'(n_digits), entered.size());
        chk("err", 32'(err), int'(m_err));
        cnt_ok  += int'(okSAVE);
        cnt_err += int'(err);
    endtask

    task automatic set_line(input int c, input logic v);
        if (c == 0) key_press = v;
        else if (c == 1) btn_save = v;
        else btn_clear = v;
    endtask

    task automatic press(input int c, input logic [3:0] d, output int oks, output int errs);
        int o0 = cnt_ok, e0 = cnt_err;
        key_digit = d;
        set_line(c, 1'b1);
        repeat (D + 6) tick();
        set_line(c, 1'b0);
        repeat (D + 6) tick();
        oks  = cnt_ok - o0;
        errs = cnt_err - e0;
    endtask

    initial begin
        int oks, errs, first, o0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("reset_num", 32'(num), 0);
        chk("reset_n", 32'(n_digits), 0);
        chk("reset_ok", 32'(okSAVE), 0);

        // reset mid-entry
        press(0, 4'd4, oks, errs);
        chk("mid_n_before", 32'(n_digits), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_num", 32'(num), 0);
        chk("mid_rst_n", 32'(n_digits), 0);
        chk("mid_rst_ok", 32'(okSAVE), 0);
        press(1, 4'd0, oks, errs);
        chk("idle_save_err", 32'(errs), 1);
        chk("idle_save_ok", 32'(oks), 0);

        // 4, 2, save with latency measurement
        press(0, 4'd4, oks, errs);
        press(0, 4'd2, oks, errs);
        chk("num42", 32'(num), 42);
        chk("n2", 32'(n_digits), 2);
        o0 = cnt_ok;
        first = -1;
        btn_save = 1'b1;
        for (int i = 1; i <= D + 8; i++) begin
            tick();
            if (okSAVE && first < 0) first = i - 1;
        end
        btn_save = 1'b0;
        repeat (D + 6) tick();
        chk("save_latency", 32'(first), D + 3);
        chk("save_ok_once", 32'(cnt_ok - o0), 1);
        chk("num42_kept", 32'(num), 42);
        chk("n0_after_save", 32'(n_digits), 0);

        // bounce then stable high -> one digit
        key_digit = 4'd6;
        for (int i = 0; i < 20; i++) begin
            key_press = ((i / 2) % 2) != 0;
            tick();
        end
        key_press = 1'b1;
        repeat (D + 6) tick();
        key_press = 1'b0;
        repeat (D + 6) tick();
        chk("bounce_n", 32'(n_digits), 1);
        chk("bounce_num", 32'(num), 6);
        o0 = cnt_ok;
        btn_save = 1'b1;
        repeat (3) tick();
        btn_save = 1'b0;
        repeat (D + 6) tick();
        chk("glitch_no_ok", 32'(cnt_ok - o0), 0);
        chk("glitch_n", 32'(n_digits), 1);
        press(2, 4'd0, oks, errs);
        chk("clear_num", 32'(num), 0);

        // boundaries
        press(0, 4'd9, oks, errs);
        press(0, 4'd9, oks, errs);
        chk("num99", 32'(num), 99);
        press(0, 4'd5, oks, errs);
        chk("third_digit_err", 32'(errs), 1);
        chk("num99_kept", 32'(num), 99);
        press(1, 4'd0, oks, errs);
        chk("save99_ok", 32'(oks), 1);
        press(2, 4'd0, oks, errs);
        press(0, 4'hC, oks, errs);
        chk("bad_digit_err", 32'(errs), 1);
        chk("bad_digit_n", 32'(n_digits), 0);

        // simultaneous clear + save
        press(0, 4'd3, oks, errs);
        press(0, 4'd7, oks, errs);
        chk("num37", 32'(num), 37);
        o0 = cnt_ok;
        btn_clear = 1'b1;
        btn_save = 1'b1;
        repeat (D + 6) tick();
        btn_clear = 1'b0;
        btn_save = 1'b0;
        repeat (D + 6) tick();
        chk("simul_no_ok", 32'(cnt_ok - o0), 0);
        chk("simul_num", 32'(num), 0);
        chk("simul_n", 32'(n_digits), 0);

        // save after save
        press(0, 4'd7, oks, errs);
        press(1, 4'd0, oks, errs);
        chk("s1_ok", 32'(oks), 1);
        chk("s1_num", 32'(num), 7);
        press(0, 4'd3, oks, errs);
        chk("s2_digit_num", 32'(num), 3);
        chk("s2_digit_n", 32'(n_digits), 1);
        press(1, 4'd0, oks, errs);
        chk("s2_ok", 32'(oks), 1);
        chk("s2_num", 32'(num), 3);

        // random mix, checked every cycle against the model
        for (int i = 0; i < 200; i++) begin
            {btn_clear, btn_save, key_press} = 3'($urandom);
            if ($urandom_range(0, 3) == 0) btn_clear = 1'b0;
            key_digit = 4'($urandom_range(0, 11));
            reset = ($urandom_range(0, 60) == 0);
            repeat ($urandom_range(1, D + 6)) tick();
            reset = 1'b0;
        end
        {btn_clear, btn_save, key_press} = 3'b000;
        repeat (D + 6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
